// File: rtl/mpsoc_ahb3_master_port_if.sv
// AHB3-Lite bus bundle between a single master port and its slave side.
// Signal names follow the AMBA AHB3-Lite naming.
interface mpsoc_ahb3_master_port_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic [PLEN-1:0] HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mpsoc_ahb3_master_port.sv
// Single-channel AHB3-Lite master: valid/ready commands become pipelined SINGLE
// transfers, one registered response each, with ERROR cancel-and-reissue.
module mpsoc_ahb3_master_port #(
  parameter int         PLEN      = 32,
  parameter int         XLEN      = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic            HCLK,
  input  logic            HRESET,

  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [PLEN-1:0] cmd_addr,
  input  logic            cmd_we,
  input  logic [2:0]      cmd_size,
  input  logic [XLEN-1:0] cmd_wdata,

  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,

  mpsoc_ahb3_master_port_if.master ahb
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  logic            ap_valid_r;
  logic            dp_valid_r;
  logic            dp_we_r;
  logic            hold_r;
  logic [XLEN-1:0] wdata_ap_r;
  logic [PLEN-1:0] haddr_r;
  logic            hwrite_r;
  logic [2:0]      hsize_r;
  logic [1:0]      htrans_r;
  logic [XLEN-1:0] hwdata_r;
  logic            rsp_valid_r;
  logic [XLEN-1:0] rsp_rdata_r;
  logic            rsp_err_r;

  logic err1_s;
  logic cmd_ready_s;
  logic accept_s;
  logic handoff_s;
  logic complete_s;
  logic ap_valid_nxt_s;
  logic dp_valid_nxt_s;
  logic hold_nxt_s;

  // err1 marks the first cycle of a two-cycle ERROR response
  assign err1_s      = dp_valid_r & ahb.HRESP & ~ahb.HREADY;
  assign cmd_ready_s = ~ap_valid_r | (ahb.HREADY & ~hold_r & ~err1_s);
  assign accept_s    = cmd_valid & cmd_ready_s;
  assign handoff_s   = ahb.HREADY & ap_valid_r & ~hold_r;
  assign complete_s  = dp_valid_r & ahb.HREADY;

  // Next-state of the address-phase, data-phase and ERROR-hold flags
  always_comb begin
    ap_valid_nxt_s = ap_valid_r;
    dp_valid_nxt_s = dp_valid_r;
    hold_nxt_s     = hold_r;

    if (accept_s) begin
      ap_valid_nxt_s = 1'b1;
    end else if (handoff_s) begin
      ap_valid_nxt_s = 1'b0;
    end else begin
      ap_valid_nxt_s = ap_valid_r;
    end

    if (handoff_s) begin
      dp_valid_nxt_s = 1'b1;
    end else if (complete_s) begin
      dp_valid_nxt_s = 1'b0;
    end else begin
      dp_valid_nxt_s = dp_valid_r;
    end

    if (complete_s) begin
      hold_nxt_s = 1'b0;
    end else if (err1_s && ap_valid_r) begin
      hold_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Pipeline state, registered AHB outputs and the response register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid_r  <= 1'b0;
      dp_valid_r  <= 1'b0;
      dp_we_r     <= 1'b0;
      hold_r      <= 1'b0;
      wdata_ap_r  <= '0;
      haddr_r     <= '0;
      hwrite_r    <= 1'b0;
      hsize_r     <= 3'b000;
      htrans_r    <= HTRANS_IDLE;
      hwdata_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      ap_valid_r  <= ap_valid_nxt_s;
      dp_valid_r  <= dp_valid_nxt_s;
      hold_r      <= hold_nxt_s;
      // HTRANS is computed from the next-state flags so the bus sees a flop
      htrans_r    <= (ap_valid_nxt_s && !hold_nxt_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (accept_s) begin
        haddr_r    <= cmd_addr;
        hwrite_r   <= cmd_we;
        hsize_r    <= cmd_size;
        wdata_ap_r <= cmd_wdata;
      end
      if (handoff_s) begin
        dp_we_r  <= hwrite_r;
        hwdata_r <= wdata_ap_r;
      end
      rsp_valid_r <= complete_s;
      rsp_err_r   <= complete_s & ahb.HRESP;
      if (complete_s) begin
        rsp_rdata_r <= dp_we_r ? {XLEN{1'b0}} : ahb.HRDATA;
      end
    end
  end

  assign cmd_ready     = cmd_ready_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_err       = rsp_err_r;

  assign ahb.HADDR     = haddr_r;
  assign ahb.HWRITE    = hwrite_r;
  assign ahb.HSIZE     = hsize_r;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HTRANS    = htrans_r;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = hwdata_r;

endmodule
